dotmatrix_scan_ctrl: RTL and testbench
======================================

# dotmatrix_scan_ctrl

Scan and animation controller for the 16x16 pedestrian-signal dot matrix. It walks the 4-bit row address into the combinational pattern ROMs and selects which ROM frame is active. It latches the returned 16-bit column word and drives the one-hot row select, inserting a blanking gap between rows to prevent ghosting. It sits between the traffic-light sequencer (which supplies `walk`) and the matrix driver pins.

## Interface
- `ROW_TICKS`, 1000: clocks per row slot, including blanking; must be > `BLANK_TICKS`.
- `BLANK_TICKS`, 8: clocks per slot with row and col forced off; must be ≥ 1.
- `STEP_FRAMES`, 25: full 16-row scans per animation step.
- `N_PATS`, 4: number of pattern ROMs. Pattern 0 is the standing figure; 1..N_PATS-1 are walking frames.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: scan enable.
- `walk` in 1: pedestrian-go request from the light sequencer.
- `row_bin` out 4: row address to the pattern ROMs.
- `pat_sel` out 2: pattern ROM select to the external column mux.
- `col_in` in 16: column word from the muxed ROM, combinational in `row_bin`/`pat_sel`.
- `row` out 16: one-hot row drive, active-high.
- `col` out 16: registered column drive, active-high.
- `frame_done` out 1: one-cycle pulse at each 15→0 row wrap.

## Operation
- Reset values: state BLANK, tick 0, `row_bin` 0, frame_cnt 0, `pat_sel` 0, `row` 0, `col` 0, `frame_done` 0.
- **FSM BLANK**
  - `row` = 0 and `col` = 0.
  - tick counts 0..BLANK_TICKS-1.
  - On the last tick: `col` ← `col_in`, `row` ← onehot(`row_bin`), tick ← 0, go to SHOW.
- **FSM SHOW**
  - tick counts 0..ROW_TICKS-BLANK_TICKS-1.
  - On the last tick: `row` ← 0, `col` ← 0, `row_bin` ← `row_bin`+1 (wraps 15→0), go to BLANK.
- **Frame boundary** (SHOW exit with `row_bin`=15):
  - `frame_done` = 1 for one cycle.
  - If `walk`=0: `pat_sel` ← 0 and frame_cnt ← 0.
  - Else, if frame_cnt = STEP_FRAMES-1: frame_cnt ← 0; `pat_sel` ← 1 if current value is 0 or N_PATS-1, else `pat_sel`+1.
  - Else: frame_cnt ← frame_cnt+1.
- `pat_sel` changes only at a frame boundary, so a displayed frame never tears.
- `walk` edges are honoured only at the next frame boundary.
- `en`=0 (evaluated every cycle, below reset in priority):
  - Next edge forces state BLANK, tick 0, `row_bin` 0, frame_cnt 0, `row` 0, `col` 0, `frame_done` 0.
  - `pat_sel` holds.
  - When `en` returns to 1, the scan restarts at row 0 in BLANK.
- Reset mid-operation overrides everything; all state takes its reset value on the next edge.
- Counter widths: tick counter is clog2(ROW_TICKS) bits; frame counter is clog2(STEP_FRAMES) bits, minimum 1 bit each.

## Timing
- Row slot is exactly ROW_TICKS clocks: BLANK_TICKS dark, then ROW_TICKS-BLANK_TICKS lit.
- Frame is exactly 16×ROW_TICKS clocks.
- `row_bin`/`pat_sel` are stable for BLANK_TICKS cycles before `col_in` is sampled, so ROM settling needs only one cycle.
- `row` and `col` change on the same edge and are never non-zero in different rows.
- `frame_done` asserts on the edge that moves `row_bin` 15→0. `pat_sel` updates on that same edge.
- First lit row after reset release: `row`=16'h0001 on edge BLANK_TICKS.

## Structure
- Shared package `matrix_pkg`:
  - FSM state encodings `ST_BLANK`, `ST_SHOW`.
  - `MATRIX_ROWS`=16.
  - `PAT_STAND`=0.
  - Width constants `ROW_W`=4, `COL_W`=16.
- Sub-module `row_decode4to16`: combinational one-hot decoder used for the `row` latch.
- The ROM mux stays outside this block.

## Test plan
Parameters for all scenarios: ROW_TICKS=10, BLANK_TICKS=2, STEP_FRAMES=2, N_PATS=4.
- **Reset:** `rst_n`=0 for 5 cycles → all outputs 0. After release, `row`=16'h0001 on cycle 2 with `col` equal to `col_in` for row_bin 0.
- **Scan:** drive `col_in` = {12'h0, row_bin} with `en`=1.
  - `row` one-hot advances every 10 cycles with a 2-cycle all-zero gap.
  - `col` matches the row index.
  - `frame_done` pulses every 160 cycles.
- **Animation:** `walk`=1 from reset → `pat_sel` stays 0 for frame 1, then steps 1 at cycle 320, 2 at 640, 3 at 960, and 1 at 1280.
- **Walk drop:** `walk` falls at row 7 while `pat_sel`=2 → `pat_sel` holds 2 until the next 15→0 wrap, then becomes 0.
- **Enable:** `en`=0 during SHOW of row 9 → next edge `row`=0, `col`=0, `row_bin`=0. On `en`=1, BLANK of row 0 restarts and `pat_sel` is unchanged.
- **Mid-scan reset:** `rst_n`=0 for 1 cycle during SHOW of row 12 → all state at reset values on the next edge; rescan begins at row 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the pedestrian-signal dot-matrix scan logic.
package matrix_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam int MATRIX_ROWS = 16;
    localparam int PAT_STAND   = 0;
    localparam int ROW_W       = 4;
    localparam int COL_W       = 16;

    // Counter width for a modulus-n counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_decode4to16.sv
// Binary row address to one-hot row drive.
module row_decode4to16
    import matrix_pkg::*;
(
    input  logic [ROW_W-1:0] bin,
    output logic [COL_W-1:0] onehot
);

    // Set exactly the bit addressed by bin.
    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/dotmatrix_scan_ctrl.sv
// Row scan and walking-figure animation controller for the 16x16 matrix.
// Each row slot is a dark blanking gap followed by the lit period; the
// column word is latched from the external ROM mux at the end of the gap.
module dotmatrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 8,
    parameter int STEP_FRAMES = 25,
    parameter int N_PATS      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             walk,
    output logic [ROW_W-1:0] row_bin,
    output logic [1:0]       pat_sel,
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             frame_done
);

    localparam int TICK_W = cnt_w(ROW_TICKS);
    localparam int FRM_W  = cnt_w(STEP_FRAMES);
    localparam int PAT_W  = 2;

    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
    localparam logic [TICK_W-1:0] SHOW_LAST  = TICK_W'(ROW_TICKS - BLANK_TICKS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(STEP_FRAMES - 1);
    localparam logic [PAT_W-1:0]  PAT_LAST   = PAT_W'(N_PATS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(MATRIX_ROWS - 1);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [ROW_W-1:0]   row_bin_q, row_bin_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [PAT_W-1:0]   pat_sel_q, pat_sel_d;
    logic [COL_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               frame_done_q, frame_done_d;

    logic [COL_W-1:0]   row_onehot;
    logic               last_tick;
    logic               frame_wrap;

    row_decode4to16 u_row_decode (
        .bin    (row_bin_q),
        .onehot (row_onehot)
    );

    // Phase-end detection shared by the next-state and datapath logic.
    always_comb begin
        last_tick  = (state_q == ST_BLANK) ? (tick_q == BLANK_LAST)
                                           : (tick_q == SHOW_LAST);
        frame_wrap = (state_q == ST_SHOW) && last_tick && (row_bin_q == ROW_LAST);
    end

    // State register and all datapath flops; everything clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            tick_q       <= '0;
            row_bin_q    <= '0;
            frame_cnt_q  <= '0;
            pat_sel_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            row_bin_q    <= row_bin_d;
            frame_cnt_q  <= frame_cnt_d;
            pat_sel_q    <= pat_sel_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: alternate BLANK/SHOW at each phase end; disable parks in BLANK.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_BLANK;
        end else if (last_tick) begin
            state_d = (state_q == ST_BLANK) ? ST_SHOW : ST_BLANK;
        end
    end

    // Datapath: tick count, row latch, row advance and animation stepping.
    always_comb begin
        tick_d       = tick_q;
        row_bin_d    = row_bin_q;
        frame_cnt_d  = frame_cnt_q;
        pat_sel_d    = pat_sel_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        if (!en) begin
            // Pattern select is kept so the animation resumes where it left off.
            tick_d      = '0;
            row_bin_d   = '0;
            frame_cnt_d = '0;
            row_d       = '0;
            col_d       = '0;
        end else if (!last_tick) begin
            tick_d = tick_q + 1'b1;
        end else begin
            tick_d = '0;
            if (state_q == ST_BLANK) begin
                // ROM address has been stable for the whole gap, so col_in is settled.
                col_d = col_in;
                row_d = row_onehot;
            end else begin
                row_d     = '0;
                col_d     = '0;
                row_bin_d = row_bin_q + 1'b1;
                if (frame_wrap) begin
                    // Pattern changes only here so a displayed frame never tears.
                    frame_done_d = 1'b1;
                    if (!walk) begin
                        pat_sel_d   = PAT_W'(PAT_STAND);
                        frame_cnt_d = '0;
                    end else if (frame_cnt_q == FRM_LAST) begin
                        frame_cnt_d = '0;
                        pat_sel_d   = ((pat_sel_q == PAT_W'(PAT_STAND)) || (pat_sel_q == PAT_LAST))
                                      ? PAT_W'(1) : pat_sel_q + 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    assign row_bin    = row_bin_q;
    assign pat_sel    = pat_sel_q;
    assign row        = row_q;
    assign col        = col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dotmatrix_scan_ctrl.sv
// Self-checking bench for dotmatrix_scan_ctrl against a clock-count model.
module tb_dotmatrix_scan_ctrl;

    localparam int RT = 10;
    localparam int BT = 2;
    localparam int SF = 2;
    localparam int NP = 4;
    localparam int FR = 16 * RT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        walk = 1'b0;
    logic [3:0]  row_bin;
    logic [1:0]  pat_sel;
    logic [15:0] col_in;
    logic [15:0] row;
    logic [15:0] col;
    logic        frame_done;

    logic [15:0] rom [NP][16];

    int checks = 0;
    int errors = 0;

    // Model: edges since scan (re)start, plus animation position.
    int          n = 0;
    int          pat_m = 0;
    int          fcnt_m = 0;
    logic [15:0] e_row, e_col;
    logic [3:0]  e_rb;
    logic [1:0]  e_pat;
    logic        e_fd;

    dotmatrix_scan_ctrl #(
        .ROW_TICKS   (RT),
        .BLANK_TICKS (BT),
        .STEP_FRAMES (SF),
        .N_PATS      (NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .walk       (walk),
        .row_bin    (row_bin),
        .pat_sel    (pat_sel),
        .col_in     (col_in),
        .row        (row),
        .col        (col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always_comb col_in = rom[pat_sel][row_bin];

    task automatic load_rom(input bit randomize);
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < 16; r++)
                rom[p][r] = randomize ? 16'($urandom) : 16'(r);
    endtask

    // Advance one clock and derive expected outputs from elapsed time.
    task automatic step();
        logic r_s, e_s, w_s;
        int r, ph;
        r_s = rst_n; e_s = en; w_s = walk;
        @(posedge clk);
        #1;
        if (!r_s) begin
            n = 0; pat_m = 0; fcnt_m = 0;
        end else if (!e_s) begin
            n = 0; fcnt_m = 0;
        end else begin
            n++;
            if (n % FR == 0) begin
                if (!w_s) begin
                    pat_m = 0; fcnt_m = 0;
                end else if (fcnt_m == SF - 1) begin
                    fcnt_m = 0;
                    pat_m = (pat_m == 0 || pat_m == NP - 1) ? 1 : pat_m + 1;
                end else begin
                    fcnt_m++;
                end
            end
        end
        r     = (n / RT) % 16;
        ph    = n % RT;
        e_rb  = 4'(r);
        e_pat = 2'(pat_m);
        e_row = (ph >= BT) ? (16'h1 << r) : 16'h0;
        e_col = (ph >= BT) ? rom[pat_m][r] : 16'h0;
        e_fd  = (n > 0) && (n % FR == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; walk = 1'b0;
        load_rom(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({row, col, row_bin, pat_sel, frame_done} !== 39'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got row=%h col=%h rb=%0d pat=%0d fd=%b want all 0",
                         i, row, col, row_bin, pat_sel, frame_done);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (row !== 16'h0) begin
            errors++; $display("FAIL reset_dark_edge1 got row=%h want 0000", row);
        end
        step();
        checks++;
        if (row !== 16'h0001) begin
            errors++; $display("FAIL reset_first_row got row=%h want 0001", row);
        end
        checks++;
        if (col !== rom[0][0]) begin
            errors++; $display("FAIL reset_first_col got col=%h want %h", col, rom[0][0]);
        end
    endtask

    task automatic test_scan();
        int pulses = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            step();
            if (frame_done) pulses++;
            checks++;
            if (row !== e_row) begin
                errors++; $display("FAIL scan_row n=%0d got %h want %h", n, row, e_row);
            end
            checks++;
            if (col !== e_col) begin
                errors++; $display("FAIL scan_col n=%0d got %h want %h", n, col, e_col);
            end
            checks++;
            if (row_bin !== e_rb) begin
                errors++; $display("FAIL scan_row_bin n=%0d got %0d want %0d", n, row_bin, e_rb);
            end
            checks++;
            if (frame_done !== e_fd) begin
                errors++; $display("FAIL scan_frame_done n=%0d got %b want %b", n, frame_done, e_fd);
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL scan_pulse_count got %0d want 2", pulses);
        end
    endtask

    task automatic test_animation();
        rst_n = 1'b0; walk = 1'b1; en = 1'b1;
        load_rom(1'b1);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 8 * FR + 5; i++) begin
            step();
            checks++;
            if (pat_sel !== e_pat || frame_done !== e_fd || col !== e_col) begin
                errors++;
                $display("FAIL anim_step n=%0d got pat=%0d fd=%b col=%h want pat=%0d fd=%b col=%h",
                         n, pat_sel, frame_done, col, e_pat, e_fd, e_col);
            end
            if (n == FR || n == 2 * FR || n == 4 * FR || n == 6 * FR || n == 8 * FR) begin
                logic [1:0] want;
                want = (n == FR) ? 2'd0 : (n == 2 * FR) ? 2'd1 : (n == 4 * FR) ? 2'd2 :
                       (n == 6 * FR) ? 2'd3 : 2'd1;
                checks++;
                if (pat_sel !== want) begin
                    errors++; $display("FAIL anim_milestone n=%0d got %0d want %0d", n, pat_sel, want);
                end
            end
        end
    endtask

    task automatic test_walk_drop();
        int budget = 0;
        walk = 1'b1;
        while (!(pat_sel == 2'd2 && row_bin == 4'd7) && budget < 6 * FR) begin
            step(); budget++;
        end
        checks++;
        if (budget >= 6 * FR) begin
            errors++; $display("FAIL walk_drop_timeout got pat=%0d want 2 at row 7", pat_sel);
        end
        walk = 1'b0;
        budget = 0;
        do begin
            step(); budget++;
            if (n % FR != 0) begin
                checks++;
                if (pat_sel !== 2'd2) begin
                    errors++; $display("FAIL walk_drop_hold n=%0d got %0d want 2", n, pat_sel);
                end
            end
        end while (n % FR != 0 && budget < 2 * FR);
        checks++;
        if (pat_sel !== 2'd0 || frame_done !== 1'b1) begin
            errors++; $display("FAIL walk_drop_wrap got pat=%0d fd=%b want pat=0 fd=1", pat_sel, frame_done);
        end
    endtask

    task automatic test_enable();
        int budget = 0;
        logic [1:0] saved;
        walk = 1'b1;
        while (!(row_bin == 4'd9 && row != 16'h0 && pat_sel != 2'd0) && budget < 8 * FR) begin
            step(); budget++;
        end
        checks++;
        if (budget >= 8 * FR) begin
            errors++; $display("FAIL enable_timeout got rb=%0d pat=%0d want row 9 lit, pat!=0", row_bin, pat_sel);
        end
        saved = pat_sel;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (row !== 16'h0 || col !== 16'h0 || row_bin !== 4'd0 || pat_sel !== saved) begin
                errors++;
                $display("FAIL enable_off got row=%h col=%h rb=%0d pat=%0d want 0/0/0/%0d",
                         row, col, row_bin, pat_sel, saved);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3 * RT; i++) begin
            step();
            checks++;
            if (row !== e_row || col !== e_col || row_bin !== e_rb || pat_sel !== saved) begin
                errors++;
                $display("FAIL enable_restart n=%0d got row=%h col=%h rb=%0d pat=%0d want %h %h %0d %0d",
                         n, row, col, row_bin, pat_sel, e_row, e_col, e_rb, saved);
            end
        end
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        while (!(row_bin == 4'd12 && row != 16'h0) && budget < 2 * FR) begin
            step(); budget++;
        end
        checks++;
        if (budget >= 2 * FR) begin
            errors++; $display("FAIL mid_reset_timeout got rb=%0d want row 12 lit", row_bin);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({row, col, row_bin, pat_sel, frame_done} !== 39'h0) begin
            errors++;
            $display("FAIL mid_reset_state got row=%h col=%h rb=%0d pat=%0d fd=%b want all 0",
                     row, col, row_bin, pat_sel, frame_done);
        end
        for (int i = 0; i < 2 * RT; i++) begin
            step();
            checks++;
            if (row !== e_row || col !== e_col || row_bin !== e_rb) begin
                errors++;
                $display("FAIL mid_reset_rescan n=%0d got row=%h col=%h rb=%0d want %h %h %0d",
                         n, row, col, row_bin, e_row, e_col, e_rb);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            if (en) begin
                if ($urandom_range(299) == 0) en = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                en = 1'b1;
            end
            if ($urandom_range(399) == 0) walk = ~walk;
            step();
            checks++;
            if (row !== e_row || col !== e_col || row_bin !== e_rb || pat_sel !== e_pat || frame_done !== e_fd) begin
                errors++;
                $display("FAIL random n=%0d got row=%h col=%h rb=%0d pat=%0d fd=%b want %h %h %0d %0d %b",
                         n, row, col, row_bin, pat_sel, frame_done, e_row, e_col, e_rb, e_pat, e_fd);
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_animation();
        test_walk_drop();
        test_enable();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
